// File: rtl/dma_hold_arbiter.sv
// rtl/dma_hold_arbiter.sv - HOLD/HOLDA bus arbiter for DMA coprocessors with round-robin and watchdog
module dma_hold_arbiter #(
  parameter int N        = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  m_hold,
  output logic [N-1:0]  m_hold_ack,
  input  logic [N-1:0]  m_we,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N*DW-1:0] m_wdata,
  output logic          cpu_hold,
  input  logic          cpu_hold_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    owner,
  output logic          busy,
  output logic          timeout_flag,
  output logic [2:0]    timeout_id,
  input  logic          timeout_clr
);

  typedef enum logic [1:0] {IDLE, CPU_REQ, GRANT, RELEASE} state_t;

  state_t       state, state_d;
  logic [2:0]   rr, rr_d, owner_d, timeout_id_d, sel_idx;
  logic [31:0]  count, count_d;
  logic [N-1:0] lock, lock_d, elig, rot, owner_oh, ack_d;
  logic         sel_valid, own_hold, wd_hit, cpu_hold_d, timeout_flag_d;

  assign elig     = m_hold & ~lock;
  assign owner_oh = N'(1) << owner;
  assign own_hold = |(m_hold & owner_oh);
  assign busy     = (state != IDLE);
  assign wd_hit   = (MAX_HOLD != 0) && (count == 32'(MAX_HOLD - 1));

  // rot[j] holds the request of master (rr+1+j) mod N, so the first set bit wins
  assign rot = N'({elig, elig} >> (32'(rr) + 32'd1));

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (!sel_valid && rot[j]) begin
        sel_valid = 1'b1;
        sel_idx   = 3'((int'(rr) + 1 + j) % N);
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == GRANT) begin
      for (int k = 0; k < N; k++) begin
        if (owner == 3'(k)) begin
          mem_we    = m_we[k];
          mem_addr  = m_addr[k*AW +: AW];
          mem_wdata = m_wdata[k*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    state_d        = state;
    cpu_hold_d     = cpu_hold;
    ack_d          = m_hold_ack;
    owner_d        = owner;
    rr_d           = rr;
    count_d        = count;
    lock_d         = lock & m_hold;
    timeout_flag_d = timeout_flag & ~timeout_clr;
    timeout_id_d   = timeout_id;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          owner_d    = sel_idx;
          cpu_hold_d = 1'b1;
          state_d    = CPU_REQ;
        end
      end
      CPU_REQ: begin
        if (!own_hold) begin
          cpu_hold_d = 1'b0;
          state_d    = RELEASE;
        end else if (cpu_hold_ack) begin
          ack_d   = owner_oh;
          count_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        count_d = count + 32'd1;
        if (!own_hold || !cpu_hold_ack || wd_hit) begin
          ack_d      = '0;
          cpu_hold_d = 1'b0;
          rr_d       = owner;
          state_d    = RELEASE;
          // a voluntary drop never counts as forced; a lost HOLDA forces release silently
          if (own_hold) begin
            lock_d = lock_d | owner_oh;
            if (cpu_hold_ack) begin
              timeout_flag_d = 1'b1;
              timeout_id_d   = owner;
            end
          end
        end
      end
      RELEASE: begin
        if (!cpu_hold_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cpu_hold     <= 1'b0;
      m_hold_ack   <= '0;
      owner        <= '0;
      rr           <= 3'(N - 1);
      count        <= '0;
      lock         <= '0;
      timeout_flag <= 1'b0;
      timeout_id   <= '0;
    end else begin
      state        <= state_d;
      cpu_hold     <= cpu_hold_d;
      m_hold_ack   <= ack_d;
      owner        <= owner_d;
      rr           <= rr_d;
      count        <= count_d;
      lock         <= lock_d;
      timeout_flag <= timeout_flag_d;
      timeout_id   <= timeout_id_d;
    end
  end

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// tb/tb_dma_hold_arbiter.sv - self-checking bench for dma_hold_arbiter with a grant-order scoreboard
module tb_dma_hold_arbiter;
  localparam int N = 4, AW = 32, DW = 32, MAX_HOLD = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  m_hold, m_hold_ack, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic          cpu_hold, cpu_hold_ack, mem_we, busy, timeout_flag, timeout_clr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    owner, timeout_id;

  int checks = 0, failures = 0;
  int exp_q[$];

  dma_hold_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .m_hold(m_hold), .m_hold_ack(m_hold_ack),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .cpu_hold(cpu_hold),
    .cpu_hold_ack(cpu_hold_ack), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .owner(owner), .busy(busy), .timeout_flag(timeout_flag),
    .timeout_id(timeout_id), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = (r == -1) ? k : -2;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cpu_hold(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_hold) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_ack(output int idx, output bit ok);
    ok = 1'b0; idx = -1;
    for (int i = 0; i < 40; i++) begin
      if (m_hold_ack != '0) begin ok = 1'b1; idx = onehot_idx(m_hold_ack); break; end
      tick();
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; m_hold = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    cpu_hold_ack = 1'b0; timeout_clr = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; m_hold = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    cpu_hold_ack = 1'b0; timeout_clr = 1'b0;
    repeat (2) tick();
    checks++;
    if ({cpu_hold, m_hold_ack, mem_we, owner, busy, timeout_flag, timeout_id} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got hold=%b ack=%b we=%b owner=%0d busy=%b tf=%b tid=%0d expected all 0",
               cpu_hold, m_hold_ack, mem_we, owner, busy, timeout_flag, timeout_id);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b cpu_hold=%b expected 0 0", busy, cpu_hold);
    end
  endtask

  task automatic test_single();
    int idx, e;
    apply_reset();
    m_hold = 4'b0001; m_we = 4'b0001;
    m_addr[0 +: AW] = 32'h100; m_wdata[0 +: DW] = 32'hCAFE0001;
    exp_q.push_back(0);
    tick();
    checks++;
    if (cpu_hold !== 1'b1 || owner !== 3'd0 || m_hold_ack !== 4'b0000 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL single_req: got hold=%b owner=%0d ack=%b we=%b expected 1 0 0000 0",
               cpu_hold, owner, m_hold_ack, mem_we);
    end
    tick(); tick();
    checks++;
    if (m_hold_ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_noack: got ack=%b expected 0000", m_hold_ack);
    end
    cpu_hold_ack = 1'b1;
    tick();
    checks++;
    if (m_hold_ack !== 4'b0001) begin
      failures++;
      $display("FAIL single_ack: got ack=%b expected 0001", m_hold_ack);
    end
    idx = onehot_idx(m_hold_ack);
    e = -1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (idx !== e) begin failures++; $display("FAIL single_grant: got %0d expected %0d", idx, e); end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hCAFE0001) begin
      failures++;
      $display("FAIL single_bus: got we=%b addr=%h wdata=%h expected 1 00000100 cafe0001",
               mem_we, mem_addr, mem_wdata);
    end
    m_hold = '0;
    tick();
    checks++;
    if (m_hold_ack !== 4'b0000 || cpu_hold !== 1'b0 || busy !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL single_release: got ack=%b hold=%b busy=%b we=%b expected 0000 0 1 0",
               m_hold_ack, cpu_hold, busy, mem_we);
    end
    cpu_hold_ack = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int idx, e, bad_we, bad_rel;
    bit ok;
    apply_reset();
    for (int k = 0; k < N; k++) begin
      m_addr[k*AW +: AW]  = 32'h1000 + k;
      m_wdata[k*DW +: DW] = 32'hD0000000 + k;
    end
    m_we = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    bad_we = 0; bad_rel = 0;
    m_hold = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_cpu_hold(ok);
      if (mem_we) bad_we++;
      cpu_hold_ack = 1'b1;
      tick();
      wait_ack(idx, ok);
      e = -1; if (exp_q.size() != 0) e = exp_q.pop_front();
      checks++;
      if (idx !== e) begin failures++; $display("FAIL rr_grant: got %0d expected %0d (grant %0d)", idx, e, g); end
      checks++;
      if (int'(owner) !== e || mem_addr !== 32'h1000 + 32'(e)) begin
        failures++;
        $display("FAIL rr_owner: got owner=%0d addr=%h expected %0d %h", owner, mem_addr, e, 32'h1000 + 32'(e));
      end
      repeat (3) tick();
      if (idx >= 0) m_hold[idx] = 1'b0;
      tick();
      if (m_hold_ack !== 4'b0000) bad_rel++;
      if (mem_we) bad_we++;
      m_hold = 4'b1111; cpu_hold_ack = 1'b0;
      tick();
      if (mem_we) bad_we++;
    end
    m_hold = '0;
    checks++;
    if (bad_we !== 0) begin failures++; $display("FAIL rr_we_gating: got %0d violations expected 0", bad_we); end
    checks++;
    if (bad_rel !== 0) begin failures++; $display("FAIL rr_release: got %0d late releases expected 0", bad_rel); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL rr_scoreboard: got %0d left expected 0", exp_q.size()); end
    tick(); tick();
  endtask

  task automatic test_watchdog();
    int idx, e, held, relock;
    bit ok;
    apply_reset();
    m_hold = 4'b0100; exp_q.push_back(2);
    wait_cpu_hold(ok);
    cpu_hold_ack = 1'b1;
    tick();
    wait_ack(idx, ok);
    e = -1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (idx !== e) begin failures++; $display("FAIL wd_grant: got %0d expected %0d", idx, e); end
    held = 0;
    for (int i = 0; i < 100 && m_hold_ack != '0; i++) begin held++; tick(); end
    checks++;
    if (held !== MAX_HOLD) begin failures++; $display("FAIL wd_hold_len: got %0d cycles expected %0d", held, MAX_HOLD); end
    checks++;
    if (timeout_flag !== 1'b1 || timeout_id !== 3'd2 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL wd_flag: got tf=%b tid=%0d hold=%b expected 1 2 0", timeout_flag, timeout_id, cpu_hold);
    end
    cpu_hold_ack = 1'b0;
    relock = 0;
    repeat (12) begin tick(); if (cpu_hold) relock++; end
    checks++;
    if (relock !== 0) begin failures++; $display("FAIL wd_lockout: got %0d request cycles expected 0", relock); end
    m_hold = '0;
    tick();
    m_hold = 4'b0100; exp_q.push_back(2);
    wait_cpu_hold(ok);
    cpu_hold_ack = 1'b1;
    tick();
    wait_ack(idx, ok);
    e = -1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (idx !== e) begin failures++; $display("FAIL wd_regrant: got %0d expected %0d", idx, e); end
    m_hold = '0;
    tick();
    cpu_hold_ack = 1'b0;
    tick();
    checks++;
    if (timeout_flag !== 1'b1) begin failures++; $display("FAIL wd_sticky: got tf=%b expected 1", timeout_flag); end
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    checks++;
    if (timeout_flag !== 1'b0) begin failures++; $display("FAIL wd_clear: got tf=%b expected 0", timeout_flag); end
  endtask

  task automatic test_abort();
    bit ack_seen;
    apply_reset();
    ack_seen = 1'b0;
    m_hold = 4'b0010;
    tick();
    checks++;
    if (cpu_hold !== 1'b1 || owner !== 3'd1) begin
      failures++;
      $display("FAIL abort_req: got hold=%b owner=%0d expected 1 1", cpu_hold, owner);
    end
    m_hold = '0; cpu_hold_ack = 1'b1;
    tick();
    if (m_hold_ack != '0) ack_seen = 1'b1;
    checks++;
    if (cpu_hold !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_drop: got hold=%b busy=%b expected 0 1", cpu_hold, busy);
    end
    tick();
    if (m_hold_ack != '0) ack_seen = 1'b1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_wait: got busy=%b expected 1", busy); end
    cpu_hold_ack = 1'b0;
    tick();
    if (m_hold_ack != '0) ack_seen = 1'b1;
    checks++;
    if (busy !== 1'b0 || ack_seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b ack_seen=%b expected 0 0", busy, ack_seen);
    end
  endtask

  task automatic test_reset_mid_grant();
    int idx, e;
    bit ok;
    apply_reset();
    m_hold = 4'b0100; m_we = 4'b0100; exp_q.push_back(2);
    wait_cpu_hold(ok);
    cpu_hold_ack = 1'b1;
    tick();
    wait_ack(idx, ok);
    e = -1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (idx !== e) begin failures++; $display("FAIL rstg_grant: got %0d expected %0d", idx, e); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cpu_hold, m_hold_ack, busy, mem_we, owner} !== '0) begin
      failures++;
      $display("FAIL rstg_async: got hold=%b ack=%b busy=%b we=%b owner=%0d expected all 0",
               cpu_hold, m_hold_ack, busy, mem_we, owner);
    end
    cpu_hold_ack = 1'b0;
    tick();
    reset_n = 1'b1; exp_q.push_back(2);
    wait_cpu_hold(ok);
    cpu_hold_ack = 1'b1;
    tick();
    wait_ack(idx, ok);
    e = -1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (idx !== e) begin failures++; $display("FAIL rstg_regrant: got %0d expected %0d", idx, e); end
    m_hold = '0;
    tick();
    cpu_hold_ack = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstg_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_holda_drop();
    int idx, e;
    bit ok;
    apply_reset();
    m_hold = 4'b0001; exp_q.push_back(0);
    wait_cpu_hold(ok);
    cpu_hold_ack = 1'b1;
    tick();
    wait_ack(idx, ok);
    e = -1; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (idx !== e) begin failures++; $display("FAIL holda_grant: got %0d expected %0d", idx, e); end
    tick();
    cpu_hold_ack = 1'b0;
    tick();
    checks++;
    if (m_hold_ack !== 4'b0000 || cpu_hold !== 1'b0 || timeout_flag !== 1'b0) begin
      failures++;
      $display("FAIL holda_release: got ack=%b hold=%b tf=%b expected 0000 0 0", m_hold_ack, cpu_hold, timeout_flag);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL holda_idle: got busy=%b expected 0", busy); end
    m_hold = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_abort();
    test_reset_mid_grant();
    test_holda_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
